safe_mode_sequencer: RTL and testbench

//   Parametrised successor of the fixed 3-signal safe-mode mux. Selects between NUM_CH

---
 rtl/safe_mode_sequencer_pkg.sv | 16 +
 rtl/safe_mode_sequencer_sat_counter.sv | 27 ++
 rtl/safe_mode_sequencer.sv | 100 ++++++++++
 tb/tb_safe_mode_sequencer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/safe_mode_sequencer_pkg.sv
// Shared definitions for the safe-mode sequencer: FSM state encodings and
// write-enable channel indices.
package safe_mode_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_NORMAL  = 2'd0,
    ST_SAFE    = 2'd1,
    ST_HOLD    = 2'd2,
    ST_RECOVER = 2'd3
  } state_t;

  localparam int CH_PC  = 0;
  localparam int CH_REG = 1;
  localparam int CH_MEM = 2;

endpackage

// File: rtl/safe_mode_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; a clear coinciding with an
// increment leaves the count at 1.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= inc ? W'(1) : '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/safe_mode_sequencer.sv
// Safe-mode sequencer: selects normal/safe write-enables and walks the
// SAFE -> HOLD -> RECOVER -> NORMAL recovery handshake after a fault.
//
//   state      | meaning
//   -----------+----------------------------------------------------------
//   ST_NORMAL  | normal write-enables pass through
//   ST_SAFE    | fault present, safe write-enables selected
//   ST_HOLD    | fault gone, counting down the minimum fault-free hold
//   ST_RECOVER | recover_req high, waiting for recover_ack
module safe_mode_sequencer
  import safe_mode_sequencer_pkg::*;
#(
  parameter int NUM_CH      = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int HOLD_W      = 5,
  parameter int FCNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fault_in,
  input  logic              fault_clear,
  input  logic [NUM_CH-1:0] normal_we,
  input  logic [NUM_CH-1:0] safe_we,
  input  logic              recover_ack,
  output logic [NUM_CH-1:0] we_out,
  output logic              safe_mode,
  output logic              recover_req,
  output logic [1:0]        state_o,
  output logic [FCNT_W-1:0] fault_count
);

  if (HOLD_CYCLES < 1 || (2**HOLD_W) <= HOLD_CYCLES) begin : g_param_chk
    $error("safe_mode_sequencer: need HOLD_CYCLES>=1 and 2**HOLD_W>HOLD_CYCLES");
  end

  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

  state_t            r_state, w_state_nxt;
  logic [HOLD_W-1:0] r_hold, w_hold_nxt;
  logic              r_safe_mode, r_recover_req;
  logic              w_enter_safe;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_NORMAL;
      r_hold        <= '0;
      r_safe_mode   <= 1'b0;
      r_recover_req <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_hold        <= w_hold_nxt;
      r_safe_mode   <= (w_state_nxt != ST_NORMAL);
      r_recover_req <= (w_state_nxt == ST_RECOVER);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    case (r_state)
      ST_NORMAL: begin
        if (fault_in) w_state_nxt = ST_SAFE;
      end
      ST_SAFE: begin
        if (!fault_in) begin
          w_state_nxt = ST_HOLD;
          w_hold_nxt  = HOLD_LOAD;
        end
      end
      ST_HOLD: begin
        if (fault_in)            w_state_nxt = ST_SAFE;
        else if (r_hold == '0)   w_state_nxt = ST_RECOVER;
        else                     w_hold_nxt  = r_hold - HOLD_W'(1);
      end
      ST_RECOVER: begin
        // A fault wins over a simultaneous ack.
        if (fault_in)         w_state_nxt = ST_SAFE;
        else if (recover_ack) w_state_nxt = ST_NORMAL;
      end
      default: w_state_nxt = ST_NORMAL;
    endcase
  end

  assign w_enter_safe = (w_state_nxt == ST_SAFE) && (r_state != ST_SAFE);

  sat_counter #(.W(FCNT_W)) u_fault_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (fault_clear),
    .inc   (w_enter_safe),
    .count (fault_count)
  );

  // fault_in masks normal writes in the same cycle, ahead of the registered flag.
  assign we_out      = (r_safe_mode | fault_in) ? safe_we : normal_we;
  assign safe_mode   = r_safe_mode;
  assign recover_req = r_recover_req;
  assign state_o     = r_state;

endmodule

// File: tb/tb_safe_mode_sequencer.sv
// Directed bench for safe_mode_sequencer: default config, a 2-bit fault
// counter config, and an 8-channel single-cycle-hold config.
module tb_safe_mode_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // default instance
  logic       a_rst, a_fault, a_clr, a_ack;
  logic [2:0] a_nwe, a_swe, a_we;
  logic       a_safe, a_req;
  logic [1:0] a_st;
  logic [7:0] a_fc;

  safe_mode_sequencer dut_a (
    .clk(clk), .rst(a_rst), .fault_in(a_fault), .fault_clear(a_clr),
    .normal_we(a_nwe), .safe_we(a_swe), .recover_ack(a_ack),
    .we_out(a_we), .safe_mode(a_safe), .recover_req(a_req),
    .state_o(a_st), .fault_count(a_fc)
  );

  // 2-bit fault counter instance
  logic       f_rst, f_fault, f_clr, f_ack;
  logic [2:0] f_nwe, f_swe, f_we;
  logic       f_safe, f_req;
  logic [1:0] f_st;
  logic [1:0] f_fc;

  safe_mode_sequencer #(.FCNT_W(2)) dut_f (
    .clk(clk), .rst(f_rst), .fault_in(f_fault), .fault_clear(f_clr),
    .normal_we(f_nwe), .safe_we(f_swe), .recover_ack(f_ack),
    .we_out(f_we), .safe_mode(f_safe), .recover_req(f_req),
    .state_o(f_st), .fault_count(f_fc)
  );

  // 8-channel, single-cycle hold instance
  logic       w_rst, w_fault, w_clr, w_ack;
  logic [7:0] w_nwe, w_swe, w_we;
  logic       w_safe, w_req;
  logic [1:0] w_st;
  logic [7:0] w_fc;

  safe_mode_sequencer #(.NUM_CH(8), .HOLD_CYCLES(1), .HOLD_W(1)) dut_w (
    .clk(clk), .rst(w_rst), .fault_in(w_fault), .fault_clear(w_clr),
    .normal_we(w_nwe), .safe_we(w_swe), .recover_ack(w_ack),
    .we_out(w_we), .safe_mode(w_safe), .recover_req(w_req),
    .state_o(w_st), .fault_count(w_fc)
  );

  int n_edges;
  int m_st;
  int m_cnt;

  // Counts edges until recover_req rises; 40 means it never did.
  task automatic edges_to_req(output int n);
    n = 40;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (a_req) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    a_rst = 1'b1; a_fault = 1'b1; a_clr = 1'b0; a_ack = 1'b0;
    a_nwe = 3'b111; a_swe = 3'b000;
    f_rst = 1'b1; f_fault = 1'b0; f_clr = 1'b0; f_ack = 1'b0;
    f_nwe = 3'b000; f_swe = 3'b000;
    w_rst = 1'b1; w_fault = 1'b0; w_clr = 1'b0; w_ack = 1'b0;
    w_nwe = 8'h00; w_swe = 8'h00;
    #1;
    chk("rst_fault_we", a_we, 3'b000);
    tick();
    tick();
    a_fault = 1'b0;
    a_rst = 1'b0; f_rst = 1'b0; w_rst = 1'b0;
    #1;
    chk("rst_state", a_st, 0);
    chk("rst_safe", a_safe, 0);
    chk("rst_req", a_req, 0);
    chk("rst_fcnt", a_fc, 0);
    chk("rst_we_normal", a_we, 3'b111);

    // ack outside RECOVER is ignored
    a_ack = 1'b1;
    tick();
    a_ack = 1'b0;
    chk("ack_ignored", a_st, 0);

    // one-cycle fault pulse in NORMAL
    a_swe = 3'b001;
    a_fault = 1'b1;
    #1;
    chk("fault_mask_we", a_we, 3'b001);
    tick();
    a_fault = 1'b0;
    chk("enter_safe_st", a_st, 1);
    chk("enter_safe_flag", a_safe, 1);
    chk("enter_safe_fcnt", a_fc, 1);
    chk("safe_we_sel", a_we, 3'b001);
    edges_to_req(n_edges);
    chk("hold_len", n_edges, 17);
    chk("recover_st", a_st, 3);
    chk("recover_we", a_we, 3'b001);
    tick();
    chk("recover_wait_req", a_req, 1);
    chk("recover_wait_st", a_st, 3);
    a_ack = 1'b1;
    tick();
    a_ack = 1'b0;
    chk("ack_normal_st", a_st, 0);
    chk("ack_normal_req", a_req, 0);
    chk("ack_normal_we", a_we, 3'b111);

    // fault mid-HOLD at count 5, then a full reload
    a_fault = 1'b1;
    tick();
    a_fault = 1'b0;
    chk("reenter_fcnt", a_fc, 2);
    tick();
    chk("hold_st", a_st, 2);
    for (int i = 0; i < 10; i++) tick();
    chk("hold_mid_st", a_st, 2);
    a_fault = 1'b1;
    tick();
    a_fault = 1'b0;
    chk("hold_fault_st", a_st, 1);
    chk("hold_fault_fcnt", a_fc, 3);
    edges_to_req(n_edges);
    chk("hold_reload_len", n_edges, 17);

    // fault and ack together in RECOVER
    a_fault = 1'b1;
    a_ack = 1'b1;
    tick();
    a_fault = 1'b0;
    a_ack = 1'b0;
    chk("rec_fault_st", a_st, 1);
    chk("rec_fault_req", a_req, 0);
    chk("rec_fault_fcnt", a_fc, 4);

    // mid-HOLD reset
    tick();
    chk("pre_rst_hold", a_st, 2);
    a_rst = 1'b1;
    tick();
    a_rst = 1'b0;
    chk("mid_hold_rst_st", a_st, 0);
    chk("mid_hold_rst_fcnt", a_fc, 0);

    // saturation with a 2-bit counter
    for (int k = 1; k <= 5; k++) begin
      f_fault = 1'b1;
      tick();
      f_fault = 1'b0;
      tick();
      if (k == 3) chk("fsat_3", f_fc, 3);
    end
    chk("fsat_5", f_fc, 3);
    chk("fsat_hold_st", f_st, 2);
    f_fault = 1'b1;
    f_clr = 1'b1;
    tick();
    f_clr = 1'b0;
    chk("fclr_entry", f_fc, 1);
    f_clr = 1'b1;
    tick();
    f_clr = 1'b0;
    chk("fclr_stay_safe", f_fc, 0);
    f_fault = 1'b0;

    // 8-channel random select against a reference state model
    m_st = 0;
    m_cnt = 0;
    for (int c = 0; c < 60; c++) begin
      w_nwe = 8'($urandom);
      w_swe = 8'($urandom);
      w_fault = ($urandom_range(3) == 0);
      w_ack = $urandom_range(1);
      #1;
      chk("w_we", w_we, ((m_st != 0) || w_fault) ? w_swe : w_nwe);
      chk("w_st", w_st, m_st);
      case (m_st)
        0: if (w_fault) m_st = 1;
        1: if (!w_fault) begin m_st = 2; m_cnt = 0; end
        2: if (w_fault) m_st = 1; else if (m_cnt == 0) m_st = 3; else m_cnt--;
        default: if (w_fault) m_st = 1; else if (w_ack) m_st = 0;
      endcase
      tick();
    end

    // single-cycle hold timing
    w_ack = 1'b0;
    w_fault = 1'b1;
    tick();
    chk("w_safe_st", w_st, 1);
    w_fault = 1'b0;
    tick();
    chk("w_hold_st", w_st, 2);
    tick();
    chk("w_rec_st", w_st, 3);
    chk("w_rec_req", w_req, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
